// File: rtl/bcd_result_formatter_if.sv
// Handshake and data bundle between the calculator front end and the
// binary-to-BCD result formatter.
interface bcd_result_formatter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      mag;
  logic                  sign_in;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  sign_out;

  modport master (
    output start, mag, sign_in,
    input  ready, busy, done, bcd, sign_out
  );

  modport slave (
    input  start, mag, sign_in,
    output ready, busy, done, bcd, sign_out
  );
endinterface

// File: rtl/bcd_result_formatter.sv
// Sequential double-dabble converter: sign-magnitude result in, packed BCD
// digits plus display sign out, one magnitude bit consumed per clock.

// One BCD digit of the add-3 correction applied before each shift.
module bcd_digit_adj (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);
  assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;
endmodule

module bcd_result_formatter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  bcd_result_formatter_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_bin;
  logic [BCD_W-1:0]   r_scr;
  logic [BCD_W-1:0]   w_adj;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_sign_out;
  logic               r_done;
  logic               w_last;

  // per-digit add-3 correction of the scratch register
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (.i_d(r_scr[4*g +: 4]), .o_d(w_adj[4*g +: 4]));
  end

  assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));
  assign bus.ready    = (r_state == S_IDLE);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.sign_out = r_sign_out;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // next-state: accept only in IDLE, WIDTH shifts, one FINISH cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_nxt = S_SHIFT;
      S_SHIFT:  if (w_last)    w_state_nxt = S_FINISH;
      S_FINISH:                w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // datapath: load, adjust-then-shift, and publish results on FINISH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bin      <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_bcd      <= '0;
      r_sign_out <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == S_FINISH);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_bin  <= bus.mag;
            r_scr  <= '0;
            r_sign <= bus.sign_in;
            r_cnt  <= '0;
          end
        end
        S_SHIFT: begin
          {r_scr, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + CNT_W'(1);
        end
        S_FINISH: begin
          // negative zero is shown as +0
          r_bcd      <= r_scr;
          r_sign_out <= r_sign & (|r_scr);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/bcd_result_formatter.md
# bcd_result_formatter

Sequential binary-to-BCD converter that consumes the sign-magnitude result produced by the lab's BCD calculator (8-bit magnitude plus sign). It turns that result into packed decimal digits for the seven-segment display path. Conversion uses an iterative shift-and-add-3 (double-dabble) datapath, one bit per clock. A ready/start/done handshake lets the calculator front end or a debounced button launch a conversion and latch the displayed value.

## Interface
- WIDTH, 8, magnitude width in bits.
- DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH − 1 (3 covers 0–255).

- clk  input  1  system clock, rising-edge.
- reset_n  input  1  reset, asynchronous, active-low.
- start  input  1  conversion request, sampled only while ready=1.
- mag  input  WIDTH  unsigned magnitude to convert, sampled with start.
- sign_in  input  1  sign of the value (1 = negative), sampled with start.
- ready  output  1  high while in IDLE, combinational from state.
- busy  output  1  high in SHIFT and FINISH states.
- done  output  1  registered, one-cycle pulse when new digits are valid.
- bcd  output  4*DIGITS  packed digits; ones at [3:0], tens at [7:4], hundreds at [11:8], and so on. Registered, held between conversions.
- sign_out  output  1  registered sign for display, forced 0 when the converted magnitude is 0.

## Operation
- State machine: IDLE → SHIFT → FINISH → IDLE.
- IDLE:
  - ready=1, busy=0.
  - On an edge with start=1: load mag into the binary shift register, clear the BCD scratch register, latch sign_in, clear the bit counter, go to SHIFT.
- SHIFT: on each edge, in this order:
  - Add 3 to every scratch digit that is ≥5.
  - Shift the {scratch, binary} pair left by one bit.
  - Increment the counter.
  - On the edge where the counter equals WIDTH−1 (the WIDTH-th shift), go to FINISH.
- FINISH: on the next edge:
  - bcd ← scratch.
  - sign_out ← latched sign AND (scratch ≠ 0).
  - done ← 1.
  - Go to IDLE.
- done is cleared on every edge where the FSM is not leaving FINISH.
- start is ignored while busy. It is not queued; a request in flight is never altered.
- mag and sign_in are don't-care except on the accepting edge.
- Negative zero (sign_in=1, mag=0) displays as +000.
- Scratch digits never exceed 9 after adjust. The counter width is ceil(log2(WIDTH)) bits.

## Timing
- Reset (asynchronous assert, any state):
  - State goes to IDLE and scratch and counter clear.
  - bcd=0, sign_out=0, done=0, busy=0, ready=1.
  - A conversion in progress is discarded and the previous bcd value is lost.
- Reset deassertion is synchronized externally. The block accepts start on the first edge after release.
- Start accepted at edge k:
  - Shifts occur on edges k+1 … k+WIDTH.
  - bcd and sign_out update and done rises at edge k+WIDTH+1.
  - done falls at edge k+WIDTH+2.
- Latency from start edge to done: WIDTH+1 cycles (9 for WIDTH=8).
- ready reasserts in the same cycle done is high. The earliest next start is accepted at edge k+WIDTH+2, giving a throughput of one conversion per WIDTH+2 cycles (10 for WIDTH=8).
- With start held high continuously, conversions run back-to-back at that rate. Each conversion samples mag on its own accepting edge.
- bcd and sign_out are stable for the whole interval between done pulses. They never show partial scratch values.

## Test plan
- Maximum value: reset, then start with mag=255, sign_in=0 → done exactly 9 cycles after the start edge, bcd=12'h255, sign_out=0, busy high for 9 cycles.
- Negative result: mag=81, sign_in=1 (−9×9 from the calculator) → bcd=12'h081, sign_out=1. Then mag=0, sign_in=1 → bcd=12'h000, sign_out=0.
- Start while busy: start with mag=100; re-pulse start with mag=7 at cycle 3 → single done pulse, bcd=12'h100, no second conversion.
- Reset mid-conversion: start mag=199, assert reset_n=0 at cycle 4 → bcd=0, done=0, ready=1 immediately. After release, start mag=100 → bcd=12'h100.
- Back-to-back: hold start=1 while feeding mag=10, 99, 200 on each accepting edge → done pulses every 10 cycles with bcd=12'h010, 12'h099, 12'h200.
- Exhaustive: all mag 0–255 × sign_in 0/1 → bcd and sign_out match the decimal reference model, done exactly once per request.
